// File: rtl/nor_cmd_seq.sv
// nor_cmd_seq: turns host NOR commands into JEDEC x16 Wishbone write sequences and waits on RY/BY#
module nor_cmd_seq #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16,
    parameter int SETTLE   = 4,
    parameter int TIMEOUT  = 2**24
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_op_i,
    input  logic [ADDRBITS-1:0] cmd_adr_i,
    input  logic [DATABITS-1:0] cmd_dat_i,
    output logic                rsp_valid_o,
    output logic                rsp_err_o,
    output logic [DATABITS-1:0] rsp_dat_o,
    output logic [ADDRBITS-1:0] wbm_adr_o,
    output logic [DATABITS-1:0] wbm_dat_o,
    output logic                wbm_we_o,
    output logic                wbm_stb_o,
    output logic                wbm_cyc_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_stall_i,
    input  logic [DATABITS-1:0] wbm_dat_i,
    input  logic                nor_ry_i,
    output logic                busy_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] OP_READ = 3'd0;
    localparam logic [2:0] OP_PROG = 3'd1;
    localparam logic [2:0] OP_SE   = 3'd2;
    localparam logic [2:0] OP_CE   = 3'd3;
    localparam logic [2:0] OP_RST  = 3'd4;
    localparam logic [ADDRBITS-1:0] A555 = ADDRBITS'(12'h555);
    localparam logic [ADDRBITS-1:0] A2AA = ADDRBITS'(12'h2AA);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACKWAIT, S_SETTLE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [2:0]          r_op;
    logic [ADDRBITS-1:0] r_adr;
    logic [DATABITS-1:0] r_dat;
    logic [DATABITS-1:0] r_rsp_dat;
    logic [2:0]          r_step;
    logic [2:0]          w_step_n;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_n;
    logic                r_gap;
    logic                w_gap_n;
    logic                r_err;
    logic                w_err_n;
    logic                r_ry_m;
    logic                r_ry_s;
    logic                w_legal;
    logic                w_final;
    logic [2:0]          w_last;
    logic                w_ack_go;
    logic                w_rd_cap;
    logic                w_stb;
    logic                w_drive;
    logic [ADDRBITS-1:0] w_adr;
    logic [DATABITS-1:0] w_dat;
    logic [DATABITS-1:0] w_fin_dat;
    logic [DATABITS-1:0] w_unl_dat;

    assign w_legal = r_op <= OP_RST;
    assign w_last  = (r_op == OP_PROG) ? 3'd3 : (r_op == OP_SE || r_op == OP_CE) ? 3'd5 : 3'd0;
    assign w_final = r_step == w_last;

    // Step 0/3 and 1/4 are the two unlock cycles; step 2 is the command byte.
    assign w_unl_dat = (r_step == 3'd1 || r_step == 3'd4) ? DATABITS'(8'h55) :
                       (r_step == 3'd2) ? ((r_op == OP_PROG) ? DATABITS'(8'hA0) : DATABITS'(8'h80)) :
                       DATABITS'(8'hAA);
    assign w_fin_dat = (r_op == OP_PROG) ? r_dat :
                       (r_op == OP_SE)   ? DATABITS'(8'h30) :
                       (r_op == OP_CE)   ? DATABITS'(8'h10) :
                       (r_op == OP_RST)  ? DATABITS'(8'hF0) : '0;
    assign w_adr = w_final ? ((r_op == OP_CE) ? A555 : r_adr) :
                   (r_step == 3'd1 || r_step == 3'd4) ? A2AA : A555;
    assign w_dat = w_final ? w_fin_dat : w_unl_dat;

    // The gap cycle keeps cyc low between consecutive bus cycles of one sequence.
    assign w_stb   = (r_state == S_ISSUE) && w_legal && !r_gap;
    assign w_drive = w_stb || (r_state == S_ACKWAIT);

    assign wbm_cyc_o   = w_drive;
    assign wbm_stb_o   = w_stb;
    assign wbm_we_o    = w_drive && (r_op != OP_READ);
    assign wbm_adr_o   = w_drive ? w_adr : '0;
    assign wbm_dat_o   = w_drive ? w_dat : '0;
    assign cmd_ready_o = r_state == S_IDLE;
    assign busy_o      = ~cmd_ready_o;
    assign rsp_valid_o = r_state == S_DONE;
    assign rsp_err_o   = rsp_valid_o & r_err;
    assign rsp_dat_o   = r_rsp_dat;

    // Next-state and step/counter sequencing; an ack taken in ISSUE behaves as in ACKWAIT.
    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_cnt_n   = r_cnt;
        w_gap_n   = r_gap;
        w_err_n   = r_err;
        w_ack_go  = 1'b0;
        w_rd_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_n = S_ISSUE;
                    w_step_n  = '0;
                    w_gap_n   = 1'b0;
                    w_err_n   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!w_legal) begin
                    w_state_n = S_DONE;
                    w_err_n   = 1'b1;
                end else if (r_gap) begin
                    w_gap_n = 1'b0;
                end else if (!wbm_stall_i) begin
                    w_state_n = S_ACKWAIT;
                    w_ack_go  = wbm_ack_i;
                end
            end
            S_ACKWAIT: w_ack_go = wbm_ack_i;
            S_SETTLE: begin
                if (r_cnt == CW'(SETTLE - 1)) begin
                    w_state_n = S_WAIT;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (r_ry_s) begin
                    w_state_n = S_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_n = S_DONE;
                    w_err_n   = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (w_ack_go) begin
            w_rd_cap = r_op == OP_READ;
            w_cnt_n  = '0;
            if (!w_final) begin
                w_state_n = S_ISSUE;
                w_step_n  = r_step + 3'd1;
                w_gap_n   = 1'b1;
            end else if (r_op == OP_READ || r_op == OP_RST) begin
                w_state_n = S_DONE;
            end else begin
                w_state_n = (SETTLE == 0) ? S_WAIT : S_SETTLE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_cnt   <= w_cnt_n;
            r_gap   <= w_gap_n;
            r_err   <= w_err_n;
        end
    end

    // Command capture on handshake and read-data capture on the READ ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_op      <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rsp_dat <= '0;
        end else begin
            if (cmd_valid_i && cmd_ready_o) begin
                r_op  <= cmd_op_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
            end
            if (w_rd_cap) r_rsp_dat <= wbm_dat_i;
        end
    end

    // Two-flop synchroniser for the asynchronous RY/BY# pin, idling ready.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ry_m <= 1'b1;
            r_ry_s <= 1'b1;
        end else begin
            r_ry_m <= nor_ry_i;
            r_ry_s <= r_ry_m;
        end
    end
endmodule

// File: tb/tb_nor_cmd_seq.sv
// tb_nor_cmd_seq: directed checks of nor_cmd_seq against a stalling/acking Wishbone slave model
module tb_nor_cmd_seq;
    localparam int AW = 26;
    localparam int DW = 16;
    localparam int ST = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_dat;
    logic [AW-1:0] wbm_adr;
    logic [DW-1:0] wbm_dat;
    logic          wbm_we, wbm_stb, wbm_cyc;
    logic          ack = 1'b0;
    logic          stall = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          ry = 1'b1;
    logic          busy;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    logic rsp_e = 1'b0;
    int last_ack = 0;
    int cyc_cnt = 0;
    int stb_cnt = 0;
    int hold_err = 0;
    int stall_n = 0;
    int stall_left = 0;
    bit pend = 1'b0;
    bit in_req = 1'b0;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic [42:0] log_q[$];
    logic [42:0] exp_q[$];
    int acc, h2, r1, s0, c0, r0;
    logic e1;

    always #5 clk = ~clk;

    nor_cmd_seq #(.ADDRBITS(AW), .DATABITS(DW), .SETTLE(ST), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_dat_o(rsp_dat),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_we_o(wbm_we),
        .wbm_stb_o(wbm_stb), .wbm_cyc_o(wbm_cyc),
        .wbm_ack_i(ack), .wbm_stall_i(stall), .wbm_dat_i(rd_data),
        .nor_ry_i(ry), .busy_o(busy)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Slave model and monitors, evaluated mid-cycle: stall stb_n cycles, ack one cycle after acceptance.
    always @(negedge clk) begin
        if (wbm_cyc) cyc_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc_n;
            rsp_e = rsp_err;
        end
        ack = pend;
        if (pend) last_ack = cyc_n;
        pend = 1'b0;
        stall = 1'b0;
        if (wbm_stb) begin
            stb_cnt++;
            if (!in_req) begin
                in_req = 1'b1;
                stall_left = stall_n;
                req_adr = wbm_adr;
                req_dat = wbm_dat;
            end else if (wbm_adr !== req_adr || wbm_dat !== req_dat) begin
                hold_err++;
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                in_req = 1'b0;
                pend = 1'b1;
                log_q.push_back({wbm_we, wbm_adr, wbm_dat});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [42:0] ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic chk_log(input string tag);
        chk({tag, "_n"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        chk("send_rdy", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_adr = a;
        cmd_dat = d;
        acc = cyc_n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 1000 && rsp_cnt < n; i++) @(posedge clk);
        chk("rsp_wait", 64'(rsp_cnt), 64'(n));
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 1000 && log_q.size() < n; i++) @(posedge clk);
        chk("log_wait", 64'(log_q.size()), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        chk("rst_rdat", 64'(rsp_dat), 64'd0);
        chk("rst_ctl", 64'({wbm_cyc, wbm_stb, wbm_we}), 64'd0);
        chk("rst_adr", 64'(wbm_adr), 64'd0);
        chk("rst_dat", 64'(wbm_dat), 64'd0);
        rst = 1'b0;

        log_q.delete();
        send(3'd1, 26'h0001234, 16'hBEEF);
        wait_log(4);
        @(negedge clk);
        ry = 1'b0;
        repeat (53) @(negedge clk);
        ry = 1'b1;
        wait_rsp(1);
        exp_q = '{ent(26'h555, 16'h00AA), ent(26'h2AA, 16'h0055), ent(26'h555, 16'h00A0), ent(26'h1234, 16'hBEEF)};
        chk_log("prog");
        chk("prog_err", 64'(rsp_e), 64'd0);
        chk("prog_min_lat", 64'(rsp_cyc - last_ack >= ST + 50), 64'd1);
        chk("prog_lat", 64'(rsp_cyc - last_ack), 64'd56);
        repeat (5) @(negedge clk);
        chk("prog_once", 64'(rsp_cnt), 64'd1);

        log_q.delete();
        stall_n = 2;
        rd_data = 16'hA5A5;
        s0 = stb_cnt;
        send(3'd0, 26'h3FFFFFF, 16'h0000);
        wait_rsp(2);
        stall_n = 0;
        chk("rd_n", 64'(log_q.size()), 64'd1);
        chk("rd_we_adr", 64'(log_q[0][42:16]), 64'({1'b0, 26'h3FFFFFF}));
        chk("rd_stb_cycles", 64'(stb_cnt - s0), 64'd3);
        chk("rd_hold", 64'(hold_err), 64'd0);
        chk("rd_data", 64'(rsp_dat), 64'hA5A5);
        chk("rd_err", 64'(rsp_e), 64'd0);
        chk("rd_lat", 64'(rsp_cyc - acc), 64'd5);

        log_q.delete();
        ry = 1'b0;
        send(3'd2, 26'h0010000, 16'h0000);
        wait_rsp(3);
        ry = 1'b1;
        exp_q = '{ent(26'h555, 16'h00AA), ent(26'h2AA, 16'h0055), ent(26'h555, 16'h0080),
                  ent(26'h555, 16'h00AA), ent(26'h2AA, 16'h0055), ent(26'h0010000, 16'h0030)};
        chk_log("se");
        chk("se_err", 64'(rsp_e), 64'd1);
        chk("se_timeout", 64'(rsp_cyc - last_ack), 64'(1 + ST + TO));

        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        cmd_adr = 26'h0ABCDEF;
        cmd_dat = 16'h0000;
        @(negedge clk);
        cmd_op = 3'd4;
        cmd_adr = 26'h0000042;
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        chk("b2b_rdy", 64'(cmd_ready), 64'd1);
        h2 = cyc_n;
        r1 = rsp_cyc;
        e1 = rsp_e;
        ry = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(5);
        ry = 1'b1;
        exp_q = '{ent(26'h555, 16'h00AA), ent(26'h2AA, 16'h0055), ent(26'h555, 16'h0080),
                  ent(26'h555, 16'h00AA), ent(26'h2AA, 16'h0055), ent(26'h555, 16'h0010),
                  ent(26'h0000042, 16'h00F0)};
        chk_log("ce_rst");
        chk("ce_err", 64'(e1), 64'd0);
        chk("b2b_gap", 64'(h2 - r1), 64'd1);
        chk("rst_cmd_lat", 64'(rsp_cyc - h2), 64'd3);
        chk("rst_cmd_err", 64'(rsp_e), 64'd0);

        log_q.delete();
        c0 = cyc_cnt;
        send(3'd6, 26'h0000000, 16'h0000);
        wait_rsp(6);
        chk("ill_cyc", 64'(cyc_cnt - c0), 64'd0);
        chk("ill_n", 64'(log_q.size()), 64'd0);
        chk("ill_err", 64'(rsp_e), 64'd1);
        chk("ill_lat", 64'(rsp_cyc - acc), 64'd2);

        log_q.delete();
        r0 = rsp_cnt;
        send(3'd1, 26'h0000777, 16'h1111);
        wait_log(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl", 64'({wbm_cyc, wbm_stb}), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
        log_q.delete();
        rd_data = 16'h5A3C;
        send(3'd0, 26'h0000100, 16'h0000);
        wait_rsp(r0 + 1);
        chk("rd2_n", 64'(log_q.size()), 64'd1);
        chk("rd2_we_adr", 64'(log_q[0][42:16]), 64'({1'b0, 26'h0000100}));
        chk("rd2_data", 64'(rsp_dat), 64'h5A3C);
        chk("rd2_err", 64'(rsp_e), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nor_cmd_seq.md
Name: nor_cmd_seq

Overview:
- Command sequencer that drives the `nor_bus` Wishbone slave as its only master.
- Turns one-shot host commands (read, word program, sector erase, chip erase, reset) into the JEDEC unlock/command write sequences for a x16 NOR device.
- After each program/erase, waits on the device RY/BY# line, with a timeout.
- Sits between the bridge's command decoder and `nor_bus`.

Parameters:
- ADDRBITS, 26, word address width (matches `nor_bus`).
- DATABITS, 16, data width.
- SETTLE, 4, cycles ignored on RY after the final command write (covers device tWB).
- TIMEOUT, 2**24, max cycles waiting for RY high before error; counter width = clog2(TIMEOUT+1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  sequencer idle; command accepted when valid&ready.
- cmd_op_i  in  3  0 READ, 1 PROGRAM, 2 SECTOR_ERASE, 3 CHIP_ERASE, 4 RESET; 5-7 illegal.
- cmd_adr_i  in  ADDRBITS  target word address / sector address.
- cmd_dat_i  in  DATABITS  program data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_err_o  out  1  qualified by rsp_valid_o: timeout or illegal op.
- rsp_dat_o  out  DATABITS  read data; held until next READ completes.
- wbm_adr_o  out  ADDRBITS  to `nor_bus` wb_adr_i.
- wbm_dat_o  out  DATABITS  to `nor_bus` wb_dat_i.
- wbm_we_o, wbm_stb_o, wbm_cyc_o  out  1 each  Wishbone master controls.
- wbm_ack_i, wbm_stall_i  in  1 each  from `nor_bus`.
- wbm_dat_i  in  DATABITS  from `nor_bus`.
- nor_ry_i  in  1  raw RY/BY# pin, asynchronous.
- busy_o  out  1  = ~cmd_ready_o.

Behaviour:
- Reset (synchronous):
  - State IDLE; cmd_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0.
  - wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0.
  - Counters cleared; RY synchroniser flops set to 1.
  - Reset mid-sequence aborts immediately. No response is issued. The device may be left mid-command; the host issues RESET afterwards.
- RY synchronisation: 2-flop synchroniser (ry_s). All RY decisions use ry_s only.
- Command capture:
  - On valid&ready, latch op, adr and dat; load step=0; cmd_ready_o falls next cycle.
  - Illegal op: go to DONE with err=1, no bus traffic.
- Step sequences (addr<-data, all writes except READ):
  - READ: adr read.
  - PROGRAM: 0x555<-AA, 0x2AA<-55, 0x555<-A0, adr<-dat, then WAIT.
  - SECTOR_ERASE: 0x555<-AA, 0x2AA<-55, 0x555<-80, 0x555<-AA, 0x2AA<-55, adr<-0030, then WAIT.
  - CHIP_ERASE: same as SECTOR_ERASE, but the last write is 0x555<-0010; then WAIT.
  - RESET: adr<-00F0; no WAIT.
  - Command bytes are zero-extended to DATABITS.
  - Unlock addresses are zero-extended to ADDRBITS.
- States: IDLE, ISSUE, ACKWAIT, SETTLE, WAIT, DONE.
- ISSUE:
  - Drive cyc=1, stb=1, we, adr, dat for the current step.
  - When stall_i=0 the request is taken: stb falls next cycle and the state goes to ACKWAIT.
  - While stall_i=1, hold all outputs stable.
- ACKWAIT:
  - cyc=1, stb=0.
  - On ack_i: cyc falls, and READ captures wbm_dat_i into rsp_dat_o.
  - On ack_i, if more steps remain: step+1, go to ISSUE. Every step is a separate cycle with cyc dropped for at least one cycle.
  - On ack_i of the last step: RESET or READ go to DONE; others go to SETTLE.
  - An ack_i arriving in the same cycle as stb (zero-wait slave) is accepted in ISSUE and treated identically.
- SETTLE: count SETTLE cycles ignoring RY, then go to WAIT.
- WAIT:
  - Timeout counter starts at 0 on entry.
  - ry_s=1: go to DONE, err=0.
  - Counter reaches TIMEOUT-1 with ry_s=0: go to DONE, err=1.
  - If both occur in the same cycle, ry_s wins (success).
- DONE:
  - rsp_valid_o=1 for exactly one cycle, with rsp_err_o; then IDLE.
  - cmd_ready_o returns to 1 the cycle after rsp_valid_o.
  - A command presented in that IDLE cycle is accepted.
- No wbm_cyc_o outside ISSUE/ACKWAIT. wbm_we_o=0 only for READ.
- Host latency: valid&ready to rsp_valid = sum of per-step bus latencies + N (one ISSUE cycle per step) + SETTLE + RY wait + 1.

Test Plan:
- PROGRAM adr=0x0001234, dat=0xBEEF; slave acks 1 cycle after stb; ry_s drops after 3 cycles and rises 50 cycles later.
  - Exactly 4 writes in order: 555/00AA, 2AA/0055, 555/00A0, 1234/BEEF.
  - rsp_valid once, err=0, no earlier than SETTLE+50 cycles after the last ack.
- READ adr=0x3FFFFFF; slave returns 0xA5A5 with stall high for 2 cycles.
  - stb/adr held during stall; single read with we=0.
  - rsp_dat_o=0xA5A5, err=0, no WAIT phase.
- SECTOR_ERASE adr=0x0010000 with TIMEOUT overridden to 100; RY held low.
  - 6 writes ending 0010000/0030.
  - rsp_err_o=1 exactly 100 cycles after WAIT entry.
- CHIP_ERASE, then RESET, issued back-to-back; second command asserted the cycle cmd_ready_o rises.
  - Chip-erase sequence ends 555/0010.
  - Second command accepted with no idle gap; RESET issues single write with data 00F0 and no RY wait.
- cmd_op=6 -> no cyc asserted; rsp_valid with err=1 two cycles after acceptance.
- wb_rst_i pulsed during ACKWAIT of step 2 of PROGRAM.
  - Next cycle: cyc=stb=0, cmd_ready_o=1, no rsp_valid.
  - A subsequent READ completes normally.
